// File: rtl/present_pkg.sv
// present_pkg
// Shared constants and types for the PRESENT command issuer:
//   KEY_W / BLK_W       - key and plaintext widths in bits
//   OP_KEY / OP_BLK     - frame header bytes selecting key or plaintext load
//   PL_IDLE/KEY/BLK     - encodings driven on the core's 'pl' command port
//   cmd_state_t         - issuer FSM states
package present_pkg;

  localparam int KEY_W = 80;
  localparam int BLK_W = 64;

  localparam logic [7:0] OP_KEY = 8'h01;
  localparam logic [7:0] OP_BLK = 8'h02;

  localparam logic [1:0] PL_IDLE = 2'b00;
  localparam logic [1:0] PL_KEY  = 2'b01;
  localparam logic [1:0] PL_BLK  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_WAIT_DONE
  } cmd_state_t;

endpackage

// File: rtl/present_cmd_issuer.sv
// present_cmd_issuer
// Collects a header byte plus a key (10 bytes) or plaintext (8 bytes) from a
// valid/ready byte stream and issues a one-cycle load command to the PRESENT
// core. After a plaintext load it waits for core_done before accepting more.
//
// Optional feature macro: PRESENT_CMD_TIMEOUT_EN
//   When defined, WAIT_DONE gives up after TIMEOUT_CYC cycles, pulsing err.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   s_data     - host byte, MSB-first within a frame
//   s_valid    - s_data valid
//   s_ready    - byte accepted when s_valid & s_ready
//   pl         - command to core (00 idle, 01 key, 10 plaintext)
//   in         - command payload, zero whenever pl is idle
//   core_done  - one-cycle completion pulse from the core
//   busy       - high in every state except IDLE
//   err        - registered one-cycle error pulse
module present_cmd_issuer
  import present_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [1:0]       pl,
  output logic [KEY_W-1:0] in,
  input  logic             core_done,
  output logic             busy,
  output logic             err
);

  cmd_state_t       state, state_next;
  logic             is_key;
  logic [3:0]       cnt;
  logic [KEY_W-1:0] asm_q;
  logic             err_q, err_next;
  logic             ready_q;
  logic             accept;
  logic             good_hdr;
  logic             last_byte;

  assign accept    = s_valid & ready_q;
  assign good_hdr  = (s_data == OP_KEY) || (s_data == OP_BLK);
  assign last_byte = (cnt == (is_key ? 4'd9 : 4'd7));

`ifdef PRESENT_CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;
  logic            to_expired;

  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Counts cycles spent in WAIT_DONE; restarts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != ST_WAIT_DONE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  // Next-state and error decision. core_done wins over timeout expiry.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (good_hdr) state_next = ST_COLLECT;
          else          err_next   = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (accept && last_byte) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_next = is_key ? ST_IDLE : ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (core_done) begin
          state_next = ST_IDLE;
        end
`ifdef PRESENT_CMD_TIMEOUT_EN
        else if (to_expired) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // s_ready is registered from the next state so it reads 0 during reset
  // and rises on the first clock after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      err_q   <= err_next;
      ready_q <= (state_next == ST_IDLE) || (state_next == ST_COLLECT);
    end
  end

  // Frame assembly: clearing on header keeps the upper 16 bits zero for
  // plaintext frames, which only shift in 8 bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_key <= 1'b0;
      cnt    <= '0;
      asm_q  <= '0;
    end else if (accept) begin
      if (state == ST_IDLE && good_hdr) begin
        is_key <= (s_data == OP_KEY);
        cnt    <= '0;
        asm_q  <= '0;
      end else if (state == ST_COLLECT) begin
        asm_q <= {asm_q[KEY_W-9:0], s_data};
        cnt   <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pl = PL_IDLE;
    in = '0;
    if (state == ST_ISSUE) begin
      pl = is_key ? PL_KEY : PL_BLK;
      in = is_key ? asm_q : {{(KEY_W-BLK_W){1'b0}}, asm_q[BLK_W-1:0]};
    end
  end

  assign s_ready = ready_q;
  assign busy    = (state != ST_IDLE);
  assign err     = err_q;

endmodule
